// File: rtl/operand_issue_if.sv
// Token types and the grouped command/token interface for the operand
// issue (transmit) end of the FTk/BTk protocol.
package operand_issue_pkg;
  localparam int WIDTH_DATA = 32;

  typedef struct packed {
    logic                  v;
    logic                  a;
    logic                  r;
    logic                  c;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;
endpackage

interface operand_issue_if #(parameter int WIDTH_LEN = 8);
  import operand_issue_pkg::*;

  logic                  I_Start;
  logic [WIDTH_LEN-1:0]  I_Length;
  logic                  I_Cond;
  logic [WIDTH_DATA-1:0] I_Data;
  logic                  I_Data_Valid;
  logic                  O_Data_Ready;
  FTk_t                  O_FTk;
  BTk_t                  I_BTk;
  logic                  O_Busy;
  logic                  O_Done;
  logic                  O_Abort;
  logic                  O_Stall;

  modport master (
    output I_Start, I_Length, I_Cond, I_Data, I_Data_Valid, I_BTk,
    input  O_Data_Ready, O_FTk, O_Busy, O_Done, O_Abort, O_Stall
  );

  modport slave (
    input  I_Start, I_Length, I_Cond, I_Data, I_Data_Valid, I_BTk,
    output O_Data_Ready, O_FTk, O_Busy, O_Done, O_Abort, O_Stall
  );
endinterface

// File: rtl/operand_issue.sv
// Operand issue: turns a ready/valid word stream into a burst of forward
// tokens, honouring nack, then closes the burst with a release token.
module operand_issue
  import operand_issue_pkg::*;
#(
  parameter int WIDTH_LEN  = 8,
  parameter int HOLD_LIMIT = 16
) (
  input logic             clock,
  input logic             reset,
  operand_issue_if.slave  issue
);

  typedef enum logic [1:0] {IDLE, SEND, RLS, DONE} state_t;

  localparam int STALL_W = $clog2(HOLD_LIMIT + 1);
  localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(HOLD_LIMIT);
  localparam logic [WIDTH_LEN-1:0] LEN_ONE   = WIDTH_LEN'(1);

  state_t               state_q, state_d;
  logic [WIDTH_LEN-1:0] count_q, count_d;
  logic [STALL_W-1:0]   stallCnt_q, stallCnt_d;
  FTk_t                 ftk_q, ftk_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 abort_q, abort_d;
  logic                 stall_q, stall_d;

  logic                 accept;
  logic                 load;
  logic [WIDTH_LEN-1:0] wordsLeft;
  logic                 unusedBtkC;

  // The FTk register doubles as the one-entry holding register; wordsLeft
  // counts words still to be pulled from the source.
  always_comb begin
    accept    = (state_q == SEND) && ftk_q.v && !issue.I_BTk.n;
    wordsLeft = count_q - {{(WIDTH_LEN-1){1'b0}}, ftk_q.v};
    load      = (state_q == SEND) && (!ftk_q.v || accept) &&
                issue.I_Data_Valid && (wordsLeft != '0);
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    stallCnt_d = stallCnt_q;
    ftk_d      = ftk_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (issue.I_Start) begin
          count_d = issue.I_Length;
          if (issue.I_Length == '0) begin
            state_d = RLS;
            ftk_d   = '0;
            ftk_d.r = 1'b1;
            ftk_d.c = issue.I_Cond;
          end else begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (accept && count_q == LEN_ONE) begin
          state_d    = RLS;
          count_d    = '0;
          stallCnt_d = '0;
          ftk_d      = '0;
          ftk_d.r    = 1'b1;
          ftk_d.c    = issue.I_Cond;
        end else begin
          if (accept) begin
            count_d    = count_q - LEN_ONE;
            stallCnt_d = '0;
            ftk_d.v    = 1'b0;
          end else if (ftk_q.v && issue.I_BTk.n && stallCnt_q < STALL_MAX) begin
            stallCnt_d = stallCnt_q + 1'b1;
          end
          if (load) begin
            ftk_d   = '0;
            ftk_d.v = 1'b1;
            ftk_d.c = issue.I_Cond;
            ftk_d.d = issue.I_Data;
          end
        end
      end
      RLS: begin
        if (issue.I_BTk.v) begin
          state_d = DONE;
          ftk_d   = '0;
          done_d  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Terminate wins over any acceptance or release-ack in the same cycle.
    if (state_q != IDLE && issue.I_BTk.t) begin
      state_d    = IDLE;
      count_d    = '0;
      stallCnt_d = '0;
      ftk_d      = '0;
      done_d     = 1'b0;
      abort_d    = 1'b1;
    end

    busy_d  = (state_d == SEND) || (state_d == RLS);
    stall_d = (stallCnt_d >= STALL_MAX);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      stallCnt_q <= '0;
      ftk_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      stallCnt_q <= stallCnt_d;
      ftk_q      <= ftk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      stall_q    <= stall_d;
    end
  end

  assign issue.O_Data_Ready = load;
  assign issue.O_FTk        = ftk_q;
  assign issue.O_Busy       = busy_q;
  assign issue.O_Done       = done_q;
  assign issue.O_Abort      = abort_q;
  assign issue.O_Stall      = stall_q;
  assign unusedBtkC         = issue.I_BTk.c;

endmodule

// File: tb/tb_operand_issue.sv
// Scoreboard bench for operand_issue: directed bursts push expected token
// events; a negedge monitor pops and compares what the DUT emits.
module tb_operand_issue;
  import operand_issue_pkg::*;

  localparam int EV_DATA  = 0;
  localparam int EV_REL   = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ABORT = 3;

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic        c;
  } evt_t;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  int   wordsTaken;

  evt_t        sbQ[$];
  logic [31:0] srcQ[$];

  operand_issue_if #(.WIDTH_LEN(8)) bus ();

  operand_issue #(.WIDTH_LEN(8), .HOLD_LIMIT(16)) dut (
    .clock (clock),
    .reset (reset),
    .issue (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectEv(input int kind, input logic [31:0] data, input logic c);
    evt_t e;
    e.kind = kind;
    e.data = data;
    e.c    = c;
    sbQ.push_back(e);
  endtask

  task automatic scoreEvent(input int kind, input logic [31:0] data, input logic c);
    evt_t e;
    if (sbQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL sb_unexpected: got event kind %0d data 0x%0h, expected none", kind, data);
    end else begin
      e = sbQ.pop_front();
      checkOutput("sb_kind", 64'(kind), 64'(e.kind));
      checkOutput("sb_data", 64'(data), 64'(e.data));
      checkOutput("sb_cond", 64'(c), 64'(e.c));
    end
  endtask

  // Monitor: accepted data tokens, acknowledged release tokens and pulses.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.O_FTk.v && !bus.I_BTk.n && !bus.I_BTk.t)
        scoreEvent(EV_DATA, bus.O_FTk.d, bus.O_FTk.c);
      if (bus.O_FTk.r && bus.I_BTk.v && !bus.I_BTk.t)
        scoreEvent(EV_REL, 32'h0, bus.O_FTk.c);
      if (bus.O_Done)
        scoreEvent(EV_DONE, 32'h0, 1'b0);
      if (bus.O_Abort)
        scoreEvent(EV_ABORT, 32'h0, 1'b0);
    end
  end

  task automatic refreshSrc();
    bus.I_Data_Valid = (srcQ.size() > 0);
    bus.I_Data       = (srcQ.size() > 0) ? srcQ[0] : 32'h0;
  endtask

  // One clock: the source pops a word if the DUT took it at this edge.
  task automatic tick();
    logic took;
    @(negedge clock);
    took = bus.O_Data_Ready && bus.I_Data_Valid && !reset;
    @(posedge clock);
    #1;
    if (took && srcQ.size() > 0) begin
      srcQ.delete(0);
      wordsTaken++;
    end
    refreshSrc();
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] len, input logic cond);
    bus.I_Start  = 1'b1;
    bus.I_Length = len;
    bus.I_Cond   = cond;
    tick();
    bus.I_Start  = 1'b0;
  endtask

  task automatic loadSrc(input logic [31:0] w[]);
    srcQ.delete();
    foreach (w[i]) srcQ.push_back(w[i]);
    wordsTaken = 0;
    refreshSrc();
  endtask

  task automatic checkDrained(input string name);
    checkOutput(name, 64'(sbQ.size()), 64'd0);
  endtask

  // Bounded wait for the release token, then acknowledge it.
  task automatic ackRelease(input string name);
    int waited = 0;
    while (!bus.O_FTk.r && waited < 10) begin
      tick();
      waited++;
    end
    checkOutput({name, "_rel_seen"}, 64'(bus.O_FTk.r), 64'd1);
    bus.I_BTk.v = 1'b1;
    tick();
    bus.I_BTk.v = 1'b0;
    checkOutput({name, "_done"}, 64'(bus.O_Done), 64'd1);
    checkOutput({name, "_busy_low"}, 64'(bus.O_Busy), 64'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] t1Data[3];
    checks = 0;
    failures = 0;
    wordsTaken = 0;
    reset = 1'b1;
    bus.I_Start = 1'b0;
    bus.I_Length = '0;
    bus.I_Cond = 1'b0;
    bus.I_Data = '0;
    bus.I_Data_Valid = 1'b0;
    bus.I_BTk = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rst_ftk", 64'(bus.O_FTk), 64'd0);
    checkOutput("rst_flags", 64'({bus.O_Data_Ready, bus.O_Busy, bus.O_Done,
                                  bus.O_Abort, bus.O_Stall}), 64'd0);

    // Burst of 3, no nack, release ack two cycles after the release token
    t1Data = '{32'h11, 32'h22, 32'h33};
    loadSrc('{32'h11, 32'h22, 32'h33});
    for (int i = 0; i < 3; i++) expectEv(EV_DATA, t1Data[i], 1'b1);
    expectEv(EV_REL, 32'h0, 1'b1);
    expectEv(EV_DONE, 32'h0, 1'b0);
    applyStimulus(8'd3, 1'b1);
    checkOutput("t1_busy", 64'(bus.O_Busy), 64'd1);
    checkOutput("t1_lat_v", 64'(bus.O_FTk.v), 64'd0);
    checkOutput("t1_ready", 64'(bus.O_Data_Ready), 64'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("t1_v", 64'(bus.O_FTk.v), 64'd1);
      checkOutput("t1_d", 64'(bus.O_FTk.d), 64'(t1Data[i]));
      tick();
    end
    checkOutput("t1_rel", 64'({bus.O_FTk.v, bus.O_FTk.r}), 64'b01);
    tick();
    tick();
    bus.I_BTk.v = 1'b1;
    tick();
    bus.I_BTk.v = 1'b0;
    checkOutput("t1_done", 64'(bus.O_Done), 64'd1);
    checkOutput("t1_busy_low", 64'(bus.O_Busy), 64'd0);
    checkOutput("t1_ftk_clear", 64'(bus.O_FTk), 64'd0);
    tick();
    checkOutput("t1_done_pulse", 64'(bus.O_Done), 64'd0);
    checkDrained("t1_drained");

    // Burst of 2 with the first token nacked for 4 cycles
    loadSrc('{32'hAA, 32'hBB, 32'hCC});
    expectEv(EV_DATA, 32'hAA, 1'b0);
    expectEv(EV_DATA, 32'hBB, 1'b0);
    expectEv(EV_REL, 32'h0, 1'b0);
    expectEv(EV_DONE, 32'h0, 1'b0);
    applyStimulus(8'd2, 1'b0);
    tick();
    bus.I_BTk.n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2_hold_d", 64'({bus.O_FTk.v, bus.O_FTk.d}), {31'd0, 1'b1, 32'hAA});
      checkOutput("t2_ready_low", 64'(bus.O_Data_Ready), 64'd0);
      tick();
    end
    bus.I_BTk.n = 1'b0;
    #1;
    checkOutput("t2_hold_last", 64'(bus.O_FTk.d), 64'hAA);
    checkOutput("t2_ready_accept", 64'(bus.O_Data_Ready), 64'd1);
    tick();
    checkOutput("t2_second", 64'({bus.O_FTk.v, bus.O_FTk.d}), {31'd0, 1'b1, 32'hBB});
    tick();
    checkOutput("t2_rel", 64'(bus.O_FTk.r), 64'd1);
    checkOutput("t2_words", 64'(wordsTaken), 64'd2);
    ackRelease("t2");
    checkDrained("t2_drained");

    // Zero-length burst: release immediately, nack on release ignored
    loadSrc('{32'h55});
    expectEv(EV_REL, 32'h0, 1'b1);
    expectEv(EV_DONE, 32'h0, 1'b0);
    applyStimulus(8'd0, 1'b1);
    checkOutput("t3_rel", 64'({bus.O_FTk.v, bus.O_FTk.r}), 64'b01);
    checkOutput("t3_busy", 64'(bus.O_Busy), 64'd1);
    checkOutput("t3_ready", 64'(bus.O_Data_Ready), 64'd0);
    bus.I_BTk.v = 1'b1;
    bus.I_BTk.n = 1'b1;
    tick();
    bus.I_BTk.v = 1'b0;
    bus.I_BTk.n = 1'b0;
    checkOutput("t3_done", 64'(bus.O_Done), 64'd1);
    checkOutput("t3_words", 64'(wordsTaken), 64'd0);
    tick();
    checkDrained("t3_drained");

    // Terminate after the second acceptance
    loadSrc('{32'h1, 32'h2, 32'h3, 32'h4});
    expectEv(EV_DATA, 32'h1, 1'b0);
    expectEv(EV_DATA, 32'h2, 1'b0);
    expectEv(EV_ABORT, 32'h0, 1'b0);
    applyStimulus(8'd4, 1'b0);
    tick();
    checkOutput("t4_d1", 64'(bus.O_FTk.d), 64'h1);
    tick();
    checkOutput("t4_d2", 64'(bus.O_FTk.d), 64'h2);
    tick();
    checkOutput("t4_d3", 64'({bus.O_FTk.v, bus.O_FTk.d}), {31'd0, 1'b1, 32'h3});
    bus.I_BTk.t = 1'b1;
    bus.I_BTk.n = 1'b1;
    tick();
    bus.I_BTk.t = 1'b0;
    bus.I_BTk.n = 1'b0;
    checkOutput("t4_abort", 64'(bus.O_Abort), 64'd1);
    checkOutput("t4_idle", 64'({bus.O_Busy, bus.O_Done}), 64'd0);
    checkOutput("t4_ftk_clear", 64'(bus.O_FTk), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t4_quiet", 64'({bus.O_FTk.v, bus.O_FTk.r, bus.O_Done, bus.O_Abort}), 64'd0);
    end
    checkOutput("t4_words", 64'(wordsTaken), 64'd3);
    checkDrained("t4_drained");

    // Nack held 20 cycles: stall rises after 16 nacked cycles
    loadSrc('{32'h77});
    expectEv(EV_DATA, 32'h77, 1'b1);
    expectEv(EV_REL, 32'h0, 1'b1);
    expectEv(EV_DONE, 32'h0, 1'b0);
    applyStimulus(8'd1, 1'b1);
    tick();
    bus.I_BTk.n = 1'b1;
    #1;
    for (int i = 1; i <= 20; i++) begin
      checkOutput("t5_stall", 64'(bus.O_Stall), 64'(i >= 17));
      tick();
    end
    bus.I_BTk.n = 1'b0;
    #1;
    checkOutput("t5_stall_held", 64'(bus.O_Stall), 64'd1);
    checkOutput("t5_token_held", 64'(bus.O_FTk.d), 64'h77);
    tick();
    checkOutput("t5_stall_clear", 64'(bus.O_Stall), 64'd0);
    ackRelease("t5");
    checkDrained("t5_drained");

    // Reset in the middle of a 5-word burst, then a clean 1-word burst
    loadSrc('{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5});
    expectEv(EV_DATA, 32'hA1, 1'b0);
    applyStimulus(8'd5, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("t6_rst_ftk", 64'(bus.O_FTk), 64'd0);
    checkOutput("t6_rst_flags", 64'({bus.O_Data_Ready, bus.O_Busy, bus.O_Done,
                                     bus.O_Abort, bus.O_Stall}), 64'd0);
    reset = 1'b0;
    checkDrained("t6_pre_drained");
    loadSrc('{32'h99});
    expectEv(EV_DATA, 32'h99, 1'b1);
    expectEv(EV_REL, 32'h0, 1'b1);
    expectEv(EV_DONE, 32'h0, 1'b0);
    applyStimulus(8'd1, 1'b1);
    ackRelease("t6");
    checkOutput("t6_words", 64'(wordsTaken), 64'd1);

    repeat (3) tick();
    checkDrained("final_drained");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
